id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage directly downstream of the fetch stage; consumes if_pc, if_insn and if_en.
- Decodes the instruction, reads two GPR operands from an asynchronous-read register file, resolves branches, and detects load-use hazards.
- Drives the registered ID/EX pipeline register and returns br_taken/br_addr to fetch.

Parameters:
- GPR_ADDR_W, 5, register index width (32 GPRs).
- LINK_REG, 31, destination register written by BSR.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- stall  in  1  hold all ID/EX registers.
- flush  in  1  squash the instruction being loaded this cycle.
- if_pc  in  30  word address following the fetched instruction (pc+1).
- if_insn  in  32  fetched instruction.
- if_en  in  1  if_insn valid.
- gpr_rd_addr_0 / gpr_rd_addr_1  out  5  register-file read addresses (insn[25:21], insn[20:16]).
- gpr_rd_data_0 / gpr_rd_data_1  in  32  register-file read data, combinational.
- ex_en, ex_gpr_we_, ex_dst_addr[5], ex_fwd_data[32]  in  EX-stage result, for forwarding.
- br_taken  out  1  redirect fetch (combinational).
- br_addr  out  30  redirect target (combinational).
- ld_hazard  out  1  load-use hazard; the controller stalls IF (combinational).
- id_pc  out  30  registered if_pc.
- id_en  out  1  ID/EX valid.
- id_alu_op  out  4  ALU operation.
- id_alu_in_0 / id_alu_in_1  out  32  ALU operands.
- id_mem_op  out  2  NOP/LDW/STW.
- id_mem_wr_data  out  32  store data.
- id_dst_addr  out  5  destination register.
- id_gpr_we_  out  1  GPR write enable, active-low.
- id_illegal  out  1  undefined opcode flag.

Behaviour:
- Instruction format: opcode[31:26], ra[25:21], rb[20:16], rc[15:11], imm[15:0].
  - R-type ALU: ADD, SUB, AND, OR, XOR, SHLL, SHRL; writes rc.
  - I-type: ADDI and ADDUI (imm sign-/zero-extended), ANDI/ORI/XORI (imm zero-extended); write rb.
  - LDW: address = ra + sext(imm), writes rb.
  - STW: address = ra + sext(imm), stores rb.
  - BE/BNE: compare ra with rb.
  - BSR: unconditional, writes LINK_REG = if_pc.
  - JR: target = ra[31:2].
- Branch target = if_pc + sext(imm), modulo 2^30; wrap-around is silent.
- br_taken = if_en & branch-condition & !ld_hazard & !stall & !flush. br_addr is valid only while br_taken=1 and is 0 otherwise.
- ld_hazard = id_en & (id_mem_op==LDW) & if_en & (id_dst_addr matches a source actually used by the current insn). Register 0 is an ordinary register.
- Register update priority: rst > stall > flush > ld_hazard > load.
  - rst: every registered output reads 0, except id_gpr_we_=1 and id_mem_op=NOP.
  - stall: all registers hold, including through ld_hazard.
  - flush or ld_hazard: load a bubble (id_en=0, id_gpr_we_=1, id_mem_op=NOP, id_illegal=0). Remaining fields are don't-care.
  - Otherwise: load the decoded fields. id_en = if_en; a non-valid insn is loaded as a bubble.
- Latency: one cycle from if_insn to the id_* registers. br_taken/br_addr and ld_hazard respond in zero cycles.
- Undefined opcode: id_illegal=1, id_gpr_we_=1, mem NOP, br_taken=0.
- Reset asserted mid-operation overrides stall and flush in that same cycle.

Optional Feature:
- Macro: ID_FWD_EN.
- Defined: a source operand equal to id_dst_addr while id_en & !id_gpr_we_ & (id_mem_op!=LDW) takes the operand bypassed from EX (ex_fwd_data when ex_en & !ex_gpr_we_ & ex_dst_addr match). The value feeds both the ALU operands and the branch compare.
- Not defined: the ex_* ports remain but are ignored. Any RAW dependency on id_dst_addr (any op with !id_gpr_we_) raises ld_hazard.

Decomposition:
- Shared package isa_pkg: opcode enum, alu_op_t (4 bit), mem_op_t (2 bit), instruction field slice constants.
- WordAddr and WordData stay in stddef.vh.
- One sub-module, id_decoder: combinational decode of opcode into control fields and immediate extension.
- id_stage holds the forwarding/hazard logic and the ID/EX register.

Test Plan:
- rst=1 for 2 cycles, then release → id_en=0, id_gpr_we_=1, id_mem_op=NOP, br_taken=0.
- ADDI r3,r1,-1, with gpr r1=5 → next cycle: id_alu_in_0=5, id_alu_in_1=32'hFFFFFFFF, id_dst_addr=3, id_gpr_we_=0.
- BE r1,r2,imm=-4, with r1=r2=7 and if_pc=30'h10 → same cycle: br_taken=1, br_addr=30'hC. With r2=8: br_taken=0.
- LDW r4 in ID, then ADD r5,r4,r1 fetched → ld_hazard=1, next id_en=0. The cycle after, ADD loads with id_en=1.
- flush=1 and stall=1 together on a valid insn → registers hold (stall wins). flush alone → id_en=0.
- ID_FWD_EN: ADD r6 in ID, then SUB r7,r6,r6 with ex_fwd_data=0x55 → both ALU operands = 0x55. Without the macro: ld_hazard=1.

Source files
------------

// File: rtl/isa_pkg.sv
// ISA encodings, field positions and decode bundle shared by the ID stage.
// The ID_FWD_EN build macro is consumed by id_stage, not here.
package isa_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RA_MSB  = 25;
    localparam int RA_LSB  = 21;
    localparam int RB_MSB  = 20;
    localparam int RB_LSB  = 16;
    localparam int RC_MSB  = 15;
    localparam int RC_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    typedef enum logic [5:0] {
        OP_ADD   = 6'h00,
        OP_SUB   = 6'h01,
        OP_AND   = 6'h02,
        OP_OR    = 6'h03,
        OP_XOR   = 6'h04,
        OP_SHLL  = 6'h05,
        OP_SHRL  = 6'h06,
        OP_ADDI  = 6'h08,
        OP_ADDUI = 6'h09,
        OP_ANDI  = 6'h0A,
        OP_ORI   = 6'h0B,
        OP_XORI  = 6'h0C,
        OP_LDW   = 6'h10,
        OP_STW   = 6'h11,
        OP_BE    = 6'h18,
        OP_BNE   = 6'h19,
        OP_BSR   = 6'h1A,
        OP_JR    = 6'h1B
    } opcode_t;

    // ALU_NOP passes operand 0 through unchanged.
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SHLL = 4'd6,
        ALU_SHRL = 4'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        MEM_NOP = 2'd0,
        MEM_LDW = 2'd1,
        MEM_STW = 2'd2
    } mem_op_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BE   = 3'd1,
        BR_BNE  = 3'd2,
        BR_BSR  = 3'd3,
        BR_JR   = 3'd4
    } br_kind_t;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_RB   = 2'd1,
        DST_RC   = 2'd2,
        DST_LINK = 2'd3
    } dst_sel_t;

    typedef struct packed {
        alu_op_t     alu_op;
        mem_op_t     mem_op;
        br_kind_t    br;
        dst_sel_t    dst_sel;
        logic        imm_sel;
        logic        link;
        logic        use_ra;
        logic        use_rb;
        logic        we;
        logic        illegal;
        logic [31:0] imm;
    } dec_t;

    function automatic logic [WORD_ADDR_W-1:0] sext_imm30(
        input logic [15:0] imm
    );
        return {{(WORD_ADDR_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decode into control fields and extended immediate.
module id_decoder
    import isa_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [15:0] i_imm,
    output dec_t        o_dec
);

    logic [31:0] w_sext;
    logic [31:0] w_zext;

    assign w_sext = {{16{i_imm[15]}}, i_imm};
    assign w_zext = {16'h0000, i_imm};

    always_comb begin
        o_dec         = '0;
        o_dec.alu_op  = ALU_NOP;
        o_dec.mem_op  = MEM_NOP;
        o_dec.br      = BR_NONE;
        o_dec.dst_sel = DST_NONE;
        o_dec.imm     = w_zext;
        unique case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHLL, OP_SHRL: begin
                o_dec.use_ra  = 1'b1;
                o_dec.use_rb  = 1'b1;
                o_dec.we      = 1'b1;
                o_dec.dst_sel = DST_RC;
            end
            OP_ADDI, OP_ADDUI, OP_ANDI,
            OP_ORI, OP_XORI: begin
                o_dec.use_ra  = 1'b1;
                o_dec.imm_sel = 1'b1;
                o_dec.we      = 1'b1;
                o_dec.dst_sel = DST_RB;
            end
            OP_LDW: begin
                o_dec.use_ra  = 1'b1;
                o_dec.imm_sel = 1'b1;
                o_dec.we      = 1'b1;
                o_dec.dst_sel = DST_RB;
                o_dec.mem_op  = MEM_LDW;
            end
            OP_STW: begin
                o_dec.use_ra  = 1'b1;
                o_dec.use_rb  = 1'b1;
                o_dec.imm_sel = 1'b1;
                o_dec.mem_op  = MEM_STW;
            end
            OP_BE: begin
                o_dec.use_ra = 1'b1;
                o_dec.use_rb = 1'b1;
                o_dec.br     = BR_BE;
            end
            OP_BNE: begin
                o_dec.use_ra = 1'b1;
                o_dec.use_rb = 1'b1;
                o_dec.br     = BR_BNE;
            end
            OP_BSR: begin
                o_dec.link    = 1'b1;
                o_dec.we      = 1'b1;
                o_dec.dst_sel = DST_LINK;
                o_dec.br      = BR_BSR;
            end
            OP_JR: begin
                o_dec.use_ra = 1'b1;
                o_dec.br     = BR_JR;
            end
            default: o_dec.illegal = 1'b1;
        endcase

        unique case (i_opcode)
            OP_ADD, OP_ADDI, OP_ADDUI,
            OP_LDW, OP_STW:       o_dec.alu_op = ALU_ADD;
            OP_SUB:               o_dec.alu_op = ALU_SUB;
            OP_AND, OP_ANDI:      o_dec.alu_op = ALU_AND;
            OP_OR, OP_ORI:        o_dec.alu_op = ALU_OR;
            OP_XOR, OP_XORI:      o_dec.alu_op = ALU_XOR;
            OP_SHLL:              o_dec.alu_op = ALU_SHLL;
            OP_SHRL:              o_dec.alu_op = ALU_SHRL;
            default:              o_dec.alu_op = ALU_NOP;
        endcase

        // Only ADDI and the address calculations sign-extend.
        if (i_opcode inside {OP_ADDI, OP_LDW, OP_STW})
            o_dec.imm = w_sext;
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: operand read, branch resolve, load-use hazard, ID/EX reg.
// Define ID_FWD_EN to bypass ALU results from EX instead of stalling.
module id_stage
    import isa_pkg::*;
#(
    parameter int GPR_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] if_pc,
    input  logic [WORD_DATA_W-1:0] if_insn,
    input  logic                   if_en,
    output logic [GPR_ADDR_W-1:0]  gpr_rd_addr_0,
    output logic [GPR_ADDR_W-1:0]  gpr_rd_addr_1,
    input  logic [WORD_DATA_W-1:0] gpr_rd_data_0,
    input  logic [WORD_DATA_W-1:0] gpr_rd_data_1,
    input  logic                   ex_en,
    input  logic                   ex_gpr_we_,
    input  logic [GPR_ADDR_W-1:0]  ex_dst_addr,
    input  logic [WORD_DATA_W-1:0] ex_fwd_data,
    output logic                   br_taken,
    output logic [WORD_ADDR_W-1:0] br_addr,
    output logic                   ld_hazard,
    output logic [WORD_ADDR_W-1:0] id_pc,
    output logic                   id_en,
    output logic [3:0]             id_alu_op,
    output logic [WORD_DATA_W-1:0] id_alu_in_0,
    output logic [WORD_DATA_W-1:0] id_alu_in_1,
    output logic [1:0]             id_mem_op,
    output logic [WORD_DATA_W-1:0] id_mem_wr_data,
    output logic [GPR_ADDR_W-1:0]  id_dst_addr,
    output logic                   id_gpr_we_,
    output logic                   id_illegal
);

    logic [WORD_ADDR_W-1:0] r_pc;
    logic                   r_en;
    alu_op_t                r_alu_op;
    logic [WORD_DATA_W-1:0] r_alu_in_0;
    logic [WORD_DATA_W-1:0] r_alu_in_1;
    mem_op_t                r_mem_op;
    logic [WORD_DATA_W-1:0] r_wr_data;
    logic [GPR_ADDR_W-1:0]  r_dst_addr;
    logic                   r_gpr_we_;
    logic                   r_illegal;

    dec_t                   w_dec;
    logic [GPR_ADDR_W-1:0]  w_ra;
    logic [GPR_ADDR_W-1:0]  w_rb;
    logic [GPR_ADDR_W-1:0]  w_rc;
    logic [15:0]            w_imm;
    logic [GPR_ADDR_W-1:0]  w_dst;
    logic [WORD_DATA_W-1:0] w_ra_data;
    logic [WORD_DATA_W-1:0] w_rb_data;
    logic [WORD_DATA_W-1:0] w_alu_in_0;
    logic [WORD_DATA_W-1:0] w_alu_in_1;
    logic                   w_ra_hit;
    logic                   w_rb_hit;
    logic                   w_ld_hazard;
    logic                   w_eq;
    logic                   w_cond;
    logic [WORD_ADDR_W-1:0] w_br_rel;
    logic [WORD_ADDR_W-1:0] w_tgt;
    logic                   w_taken;
    logic                   w_load;

    assign w_ra  = if_insn[RA_MSB:RA_LSB];
    assign w_rb  = if_insn[RB_MSB:RB_LSB];
    assign w_rc  = if_insn[RC_MSB:RC_LSB];
    assign w_imm = if_insn[IMM_MSB:IMM_LSB];

    assign gpr_rd_addr_0 = w_ra;
    assign gpr_rd_addr_1 = w_rb;

    id_decoder u_dec (
        .i_opcode (if_insn[OPC_MSB:OPC_LSB]),
        .i_imm    (w_imm),
        .o_dec    (w_dec)
    );

    always_comb begin
        case (w_dec.dst_sel)
            DST_RB:   w_dst = w_rb;
            DST_RC:   w_dst = w_rc;
            DST_LINK: w_dst = GPR_ADDR_W'(LINK_REG);
            default:  w_dst = '0;
        endcase
    end

    assign w_ra_hit = w_dec.use_ra & (w_ra == r_dst_addr);
    assign w_rb_hit = w_dec.use_rb & (w_rb == r_dst_addr);

`ifdef ID_FWD_EN
    logic w_fwd_ok;

    // Only non-load results exist in EX in time to be bypassed.
    assign w_fwd_ok = r_en & ~r_gpr_we_ & (r_mem_op != MEM_LDW)
                    & ex_en & ~ex_gpr_we_
                    & (ex_dst_addr == r_dst_addr);

    assign w_ra_data = (w_fwd_ok & (w_ra == r_dst_addr))
                     ? ex_fwd_data : gpr_rd_data_0;
    assign w_rb_data = (w_fwd_ok & (w_rb == r_dst_addr))
                     ? ex_fwd_data : gpr_rd_data_1;

    assign w_ld_hazard = r_en & (r_mem_op == MEM_LDW) & if_en
                       & (w_ra_hit | w_rb_hit);
`else
    logic w_unused;

    assign w_unused = ^{ex_en, ex_gpr_we_, ex_dst_addr, ex_fwd_data};

    assign w_ra_data = gpr_rd_data_0;
    assign w_rb_data = gpr_rd_data_1;

    assign w_ld_hazard = r_en & ~r_gpr_we_ & if_en
                       & (w_ra_hit | w_rb_hit);
`endif

    assign w_eq     = (w_ra_data == w_rb_data);
    assign w_br_rel = if_pc + sext_imm30(w_imm);

    always_comb begin
        w_cond = 1'b0;
        w_tgt  = '0;
        case (w_dec.br)
            BR_BE: begin
                w_cond = w_eq;
                w_tgt  = w_br_rel;
            end
            BR_BNE: begin
                w_cond = ~w_eq;
                w_tgt  = w_br_rel;
            end
            BR_BSR: begin
                w_cond = 1'b1;
                w_tgt  = w_br_rel;
            end
            BR_JR: begin
                w_cond = 1'b1;
                w_tgt  = w_ra_data[31:2];
            end
            default: ;
        endcase
    end

    assign w_taken = if_en & w_cond & ~w_ld_hazard & ~stall & ~flush;

    assign br_taken  = w_taken;
    assign br_addr   = w_taken ? w_tgt : '0;
    assign ld_hazard = w_ld_hazard;

    assign w_alu_in_0 = w_dec.link ? {if_pc, 2'b00} : w_ra_data;
    assign w_alu_in_1 = w_dec.imm_sel ? w_dec.imm : w_rb_data;

    assign w_load = if_en & ~flush & ~w_ld_hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_en       <= 1'b0;
            r_alu_op   <= ALU_NOP;
            r_alu_in_0 <= '0;
            r_alu_in_1 <= '0;
            r_mem_op   <= MEM_NOP;
            r_wr_data  <= '0;
            r_dst_addr <= '0;
            r_gpr_we_  <= 1'b1;
            r_illegal  <= 1'b0;
        end else if (!stall) begin
            r_pc       <= if_pc;
            r_alu_op   <= w_dec.alu_op;
            r_alu_in_0 <= w_alu_in_0;
            r_alu_in_1 <= w_alu_in_1;
            r_wr_data  <= w_rb_data;
            r_dst_addr <= w_dst;
            if (w_load) begin
                r_en      <= 1'b1;
                r_gpr_we_ <= ~w_dec.we;
                r_mem_op  <= w_dec.mem_op;
                r_illegal <= w_dec.illegal;
            end else begin
                r_en      <= 1'b0;
                r_gpr_we_ <= 1'b1;
                r_mem_op  <= MEM_NOP;
                r_illegal <= 1'b0;
            end
        end
    end

    assign id_pc          = r_pc;
    assign id_en          = r_en;
    assign id_alu_op      = r_alu_op;
    assign id_alu_in_0    = r_alu_in_0;
    assign id_alu_in_1    = r_alu_in_1;
    assign id_mem_op      = r_mem_op;
    assign id_mem_wr_data = r_wr_data;
    assign id_dst_addr    = r_dst_addr;
    assign id_gpr_we_     = r_gpr_we_;
    assign id_illegal     = r_illegal;

endmodule
